// File: rtl/pipe_stage_reg_if.sv
// Handshake/data bundle between two pipeline stages and the stage register that separates them.
// The master drives the upstream slot and control signals. The slave is the stage register itself.
interface pipe_stage_reg_if #(
  parameter int DATA_W  = 64,
  parameter int STALL_W = 6,
  parameter int CNT_W   = 8
);
  logic [STALL_W-1:0] stall;
  logic               flush;
  logic               in_valid;
  logic [31:0]        in_pc;
  logic [DATA_W-1:0]  in_payload;
  logic               out_valid;
  logic [31:0]        out_pc;
  logic [DATA_W-1:0]  out_payload;
  logic               out_bubble;
  logic [CNT_W-1:0]   hold_cnt;

  modport master (
    output stall, flush, in_valid, in_pc, in_payload,
    input  out_valid, out_pc, out_payload, out_bubble, hold_cnt
  );

  modport slave (
    input  stall, flush, in_valid, in_pc, in_payload,
    output out_valid, out_pc, out_payload, out_bubble, hold_cnt
  );
endinterface

// File: rtl/pipe_stage_reg.sv
// Generic MIPS pipeline-stage register with stall, bubble insertion, top-priority flush and
// a saturating hold-cycle counter for stall debug.
module pipe_stage_reg #(
  parameter int DATA_W      = 64,
  parameter int STALL_W     = 6,
  parameter int STAGE       = 3,
  parameter int KEEP_PC_BUB = 1,
  parameter int ZERO_INV    = 1,
  parameter int CNT_W       = 8
) (
  input  logic           clock,
  input  logic           reset,
  pipe_stage_reg_if.slave bus
);

  // The downstream stage's stall bit must exist inside the vector.
  generate
    if (STAGE > STALL_W - 2) begin : gCfgErr
      $error("pipe_stage_reg: STAGE must be <= STALL_W-2");
    end
  endgenerate

  localparam logic [CNT_W-1:0] CntMax = '1;

  logic s, sn;
  logic              valid_q,   valid_d;
  logic [31:0]       pc_q,      pc_d;
  logic [DATA_W-1:0] payload_q, payload_d;
  logic              bubble_q,  bubble_d;
  logic [CNT_W-1:0]  hold_q,    hold_d;

  assign s  = bus.stall[STAGE];
  assign sn = bus.stall[STAGE+1];

  // Mode is decided fresh every cycle. Flush beats every stall combination.
  always_comb begin
    valid_d   = valid_q;
    pc_d      = pc_q;
    payload_d = payload_q;
    bubble_d  = bubble_q;
    hold_d    = hold_q;
    if (bus.flush) begin
      valid_d   = 1'b0;
      pc_d      = '0;
      payload_d = '0;
      bubble_d  = 1'b0;
      hold_d    = '0;
    end else if (!s) begin
      valid_d   = bus.in_valid;
      pc_d      = bus.in_pc;
      payload_d = ((ZERO_INV != 0) && !bus.in_valid) ? '0 : bus.in_payload;
      bubble_d  = 1'b0;
      hold_d    = '0;
    end else if (!sn) begin
      valid_d   = 1'b0;
      pc_d      = (KEEP_PC_BUB != 0) ? bus.in_pc : '0;
      payload_d = '0;
      bubble_d  = 1'b1;
      hold_d    = '0;
    end else if (hold_q != CntMax) begin
      hold_d    = hold_q + 1'b1;
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      valid_q   <= 1'b0;
      pc_q      <= '0;
      payload_q <= '0;
      bubble_q  <= 1'b0;
      hold_q    <= '0;
    end else begin
      valid_q   <= valid_d;
      pc_q      <= pc_d;
      payload_q <= payload_d;
      bubble_q  <= bubble_d;
      hold_q    <= hold_d;
    end
  end

  assign bus.out_valid   = valid_q;
  assign bus.out_pc      = pc_q;
  assign bus.out_payload = payload_q;
  assign bus.out_bubble  = bubble_q;
  assign bus.hold_cnt    = hold_q;

endmodule

// File: tb/tb_pipe_stage_reg.sv
// Bench for pipe_stage_reg: two configurations driven in lockstep, checked every cycle against
// a rule-level model, plus directed scenarios with literal expectations.
module tb_pipe_stage_reg;

  logic        clock;
  logic        reset;
  logic [5:0]  stall;
  logic        flush;
  logic        inValid;
  logic [31:0] inPc;
  logic [63:0] inPayload;

  int checks = 0;
  int errors = 0;

  pipe_stage_reg_if #(.DATA_W(64), .STALL_W(6), .CNT_W(8)) busA ();
  pipe_stage_reg_if #(.DATA_W(64), .STALL_W(6), .CNT_W(4)) busB ();

  assign busA.stall = stall;  assign busA.flush = flush;  assign busA.in_valid = inValid;
  assign busA.in_pc = inPc;   assign busA.in_payload = inPayload;
  assign busB.stall = stall;  assign busB.flush = flush;  assign busB.in_valid = inValid;
  assign busB.in_pc = inPc;   assign busB.in_payload = inPayload;

  pipe_stage_reg #(.DATA_W(64), .STALL_W(6), .STAGE(3), .KEEP_PC_BUB(1), .ZERO_INV(1), .CNT_W(8))
    dutA (.clock(clock), .reset(reset), .bus(busA));
  pipe_stage_reg #(.DATA_W(64), .STALL_W(6), .STAGE(3), .KEEP_PC_BUB(0), .ZERO_INV(0), .CNT_W(4))
    dutB (.clock(clock), .reset(reset), .bus(busB));

  initial begin
    clock = 1'b0;
    forever #5 clock = ~clock;
  end

  // Model state per configuration: index 0 = dutA, 1 = dutB.
  bit          keepPc [2] = '{1'b1, 1'b0};
  bit          zeroInv[2] = '{1'b1, 1'b0};
  int          holdMax[2] = '{255, 15};
  logic        mValid [2];
  logic [31:0] mPc    [2];
  logic [63:0] mPay   [2];
  logic        mBub   [2];
  int          mHold  [2];

  task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s actual=%h required=%h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic applyStimulus(input logic rst, input logic fl, input logic [5:0] st,
                               input logic v, input logic [31:0] pc, input logic [63:0] pay);
    reset = rst; flush = fl; stall = st; inValid = v; inPc = pc; inPayload = pay;
    @(posedge clock);
    #2;
  endtask

  // Model advances on each edge from the inputs seen there, then both DUTs are compared.
  always @(posedge clock) begin
    for (int k = 0; k < 2; k++) begin
      if (reset || flush) begin
        mValid[k] = 1'b0; mPc[k] = '0; mPay[k] = '0; mBub[k] = 1'b0; mHold[k] = 0;
      end else if (!stall[3]) begin
        mValid[k] = inValid; mPc[k] = inPc;
        mPay[k]   = (zeroInv[k] && !inValid) ? 64'd0 : inPayload;
        mBub[k]   = 1'b0; mHold[k] = 0;
      end else if (!stall[4]) begin
        mValid[k] = 1'b0; mPay[k] = '0; mBub[k] = 1'b1; mHold[k] = 0;
        mPc[k]    = keepPc[k] ? inPc : 32'd0;
      end else begin
        mHold[k] = (mHold[k] + 1 > holdMax[k]) ? holdMax[k] : mHold[k] + 1;
      end
    end
    #1;
    checkOutput("A.valid",   64'(busA.out_valid),   64'(mValid[0]));
    checkOutput("A.pc",      64'(busA.out_pc),      64'(mPc[0]));
    checkOutput("A.payload", busA.out_payload,      mPay[0]);
    checkOutput("A.bubble",  64'(busA.out_bubble),  64'(mBub[0]));
    checkOutput("A.hold",    64'(busA.hold_cnt),    64'(mHold[0]));
    checkOutput("B.valid",   64'(busB.out_valid),   64'(mValid[1]));
    checkOutput("B.pc",      64'(busB.out_pc),      64'(mPc[1]));
    checkOutput("B.payload", busB.out_payload,      mPay[1]);
    checkOutput("B.bubble",  64'(busB.out_bubble),  64'(mBub[1]));
    checkOutput("B.hold",    64'(busB.hold_cnt),    64'(mHold[1]));
  end

  initial begin
    logic [5:0] st;
    // Reset for two cycles.
    applyStimulus(1, 0, 6'b000000, 0, 32'h0, 64'h0);
    applyStimulus(1, 0, 6'b000000, 0, 32'h0, 64'h0);
    checkOutput("T0.valid", 64'(busA.out_valid), 64'd0);
    checkOutput("T0.pc",    64'(busA.out_pc),    64'd0);
    checkOutput("T0.hold",  64'(busA.hold_cnt),  64'd0);

    applyStimulus(0, 0, 6'b000000, 1, 32'hBFC00000, 64'h1234);
    checkOutput("T1.valid",   64'(busA.out_valid),  64'd1);
    checkOutput("T1.pc",      64'(busA.out_pc),     64'hBFC00000);
    checkOutput("T1.payload", busA.out_payload,     64'h1234);
    checkOutput("T1.bubble",  64'(busA.out_bubble), 64'd0);

    applyStimulus(0, 0, 6'b001000, 1, 32'hBFC00010, 64'h5555);
    checkOutput("T2.valid",   64'(busA.out_valid),  64'd0);
    checkOutput("T2.payload", busA.out_payload,     64'd0);
    checkOutput("T2.bubble",  64'(busA.out_bubble), 64'd1);
    checkOutput("T2.pcKeep",  64'(busA.out_pc),     64'hBFC00010);
    checkOutput("T2.pcZero",  64'(busB.out_pc),     64'd0);

    applyStimulus(0, 0, 6'b000000, 1, 32'h100, 64'hAAAA);
    for (int i = 0; i < 300; i++) applyStimulus(0, 0, 6'b011000, 1, 32'h104, 64'h7777);
    checkOutput("T3.payload", busA.out_payload,   64'hAAAA);
    checkOutput("T3.holdA",   64'(busA.hold_cnt), 64'd255);
    checkOutput("T3.holdB",   64'(busB.hold_cnt), 64'd15);
    applyStimulus(0, 0, 6'b000000, 1, 32'h108, 64'hBBBB);
    checkOutput("T3.holdClr", 64'(busA.hold_cnt), 64'd0);

    for (int i = 0; i < 3; i++) applyStimulus(0, 0, 6'b011000, 1, 32'h10C, 64'h1);
    applyStimulus(0, 1, 6'b011000, 1, 32'h10C, 64'h1);
    checkOutput("T4.valid",   64'(busA.out_valid), 64'd0);
    checkOutput("T4.pc",      64'(busA.out_pc),    64'd0);
    checkOutput("T4.payload", busA.out_payload,    64'd0);
    checkOutput("T4.hold",    64'(busA.hold_cnt),  64'd0);

    applyStimulus(0, 0, 6'b000000, 0, 32'h200, 64'hFFFF);
    checkOutput("T5.payZero", busA.out_payload,    64'd0);
    checkOutput("T5.payKeep", busB.out_payload,    64'hFFFF);
    checkOutput("T5.validA",  64'(busA.out_valid), 64'd0);
    checkOutput("T5.validB",  64'(busB.out_valid), 64'd0);

    // A bubble that is then held stays a bubble.
    applyStimulus(0, 0, 6'b001000, 1, 32'h204, 64'h3);
    applyStimulus(0, 0, 6'b011000, 1, 32'h208, 64'h4);
    checkOutput("HB.bubble", 64'(busA.out_bubble), 64'd1);
    checkOutput("HB.hold",   64'(busA.hold_cnt),   64'd1);

    applyStimulus(0, 0, 6'b000000, 1, 32'h300, 64'hC0DE);
    for (int i = 0; i < 5; i++) applyStimulus(0, 0, 6'b011000, 1, 32'h304, 64'h9);
    checkOutput("T6.hold5", 64'(busA.hold_cnt), 64'd5);
    applyStimulus(1, 0, 6'b011000, 1, 32'h304, 64'h9);
    checkOutput("T6.valid",   64'(busA.out_valid), 64'd0);
    checkOutput("T6.pc",      64'(busA.out_pc),    64'd0);
    checkOutput("T6.payload", busA.out_payload,    64'd0);
    checkOutput("T6.hold",    64'(busA.hold_cnt),  64'd0);

    // Random traffic, biased so stall bits 3/4 are often set and long holds occur.
    for (int i = 0; i < 3000; i++) begin
      st    = 6'($urandom);
      st[3] = ($urandom_range(3, 0) != 0);
      st[4] = ($urandom_range(3, 0) != 0);
      applyStimulus(($urandom_range(63, 0) == 0), ($urandom_range(15, 0) == 0), st,
                    1'($urandom), $urandom, {$urandom, $urandom});
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
